// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side driver for a combinational ALU.
// It owns an NREG x DW register file and takes operate commands (op, rd, ra, rb)
// over a valid/ready handshake. Each command runs IDLE -> READ -> EXEC: it latches
// the command, drives registered operands to the ALU, then writes the result back.
// A host port can write any register on any edge and read any register
// combinationally. When a host write and a writeback hit the same register on
// the same edge, the writeback wins.
// Optional feature macro: ALU_FLAGS_EN adds flag_z/flag_n, which are updated
// on legal writebacks only.

module alu_sequencer #(
  parameter  int NREG = 8,
  parameter  int DW   = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  // Command handshake
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [15:0]   cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  // ALU interface
  output logic [15:0]   alu_inst,
  output logic [DW-1:0] alu_da,
  output logic [DW-1:0] alu_db,
  input  logic [DW-1:0] alu_out,
  // Writeback / error reporting
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          err,
`ifdef ALU_FLAGS_EN
  output logic          flag_z,
  output logic          flag_n,
`endif
  // Host register-file port
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata
);

  localparam logic [15:0] OP_ADD = 16'h0001;
  localparam logic [15:0] OP_SUB = 16'h0029;
  localparam logic [15:0] OP_AND = 16'h0021;
  localparam logic [15:0] OP_OR  = 16'h0009;
  localparam logic [15:0] OP_XOR = 16'h0031;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t          state_q;
  logic [15:0]     op_q;
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   ra_q;
  logic [AW-1:0]   rb_q;
  logic            legal_q;

  logic [15:0]     alu_inst_q;
  logic [DW-1:0]   alu_da_q;
  logic [DW-1:0]   alu_db_q;
  logic            wb_valid_q;
  logic [AW-1:0]   wb_rd_q;
  logic [DW-1:0]   wb_data_q;
  logic            err_q;

  logic [DW-1:0]   rf_q [NREG];
  logic            wb_we;

  // Opcode legality check. It is applied when the command is accepted, so the
  // legal bit travels with the command.
  function automatic logic is_legal(input logic [15:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_legal = 1'b1;
      default:                               is_legal = 1'b0;
    endcase
  endfunction

  // The register file is written in EXEC, and only for a legal opcode.
  assign wb_we = (state_q == EXEC) && legal_q;

  // Command FSM. All ALU-facing and writeback outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      legal_q    <= 1'b0;
      alu_inst_q <= '0;
      alu_da_q   <= '0;
      alu_db_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle and are raised only by the
      // EXEC branch. That makes them one-cycle strobes without extra clearing logic.
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            rd_q    <= cmd_rd;
            ra_q    <= cmd_ra;
            rb_q    <= cmd_rb;
            legal_q <= is_legal(cmd_op);
            state_q <= READ;
          end
        end
        READ: begin
          // NOTE: non-blocking reads of rf_q see the pre-edge contents, so a host
          // write on this same edge does not leak into the operands.
          alu_da_q   <= rf_q[ra_q];
          alu_db_q   <= rf_q[rb_q];
          alu_inst_q <= op_q;
          state_q    <= EXEC;
        end
        EXEC: begin
          if (legal_q) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_data_q  <= alu_out;
          end else begin
            err_q      <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  logic flag_z_q;
  logic flag_n_q;

  // Result flags. They are captured together with the legal writeback and
  // hold their value otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (wb_we) begin
      flag_z_q <= (alu_out == '0);
      flag_n_q <= alu_out[DW-1];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`endif

  // Register file. A writeback takes priority over a host write to the same
  // entry; a reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this storage is reset on purpose, because software relies on
      // reading zeros after reset. It is therefore built from flops, not RAM.
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_we && (rd_q == AW'(i))) begin
          rf_q[i] <= alu_out;
        end else if (host_we && (host_addr == AW'(i))) begin
          rf_q[i] <= host_wdata;
        end
      end
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign alu_inst   = alu_inst_q;
  assign alu_da     = alu_da_q;
  assign alu_db     = alu_db_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign err        = err_q;
  assign host_rdata = rf_q[host_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer. It contains a small
// behavioural ALU that closes the inst/da/db -> out loop.
// Build with +define+ALU_FLAGS_EN to include the flag checks.

module tb_alu_sequencer;

  localparam logic [15:0] OP_ADD = 16'h0001;
  localparam logic [15:0] OP_SUB = 16'h0029;
  localparam logic [15:0] OP_AND = 16'h0021;
  localparam logic [15:0] OP_OR  = 16'h0009;
  localparam logic [15:0] OP_XOR = 16'h0031;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_op = '0;
  logic [2:0]  cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
  logic [15:0] alu_inst;
  logic [31:0] alu_da, alu_db, alu_out;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;
`ifdef ALU_FLAGS_EN
  logic        flag_z, flag_n;
`endif
  logic        host_we = 1'b0;
  logic [2:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic [31:0] host_rdata;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Behavioural ALU driven by the DUT's registered outputs
  always_comb begin
    case (alu_inst)
      OP_ADD:  alu_out = alu_da + alu_db;
      OP_SUB:  alu_out = alu_da - alu_db;
      OP_AND:  alu_out = alu_da & alu_db;
      OP_OR:   alu_out = alu_da | alu_db;
      OP_XOR:  alu_out = alu_da ^ alu_db;
      default: alu_out = 32'h0;
    endcase
  end

  alu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_ra     (cmd_ra),
    .cmd_rb     (cmd_rb),
    .alu_inst   (alu_inst),
    .alu_da     (alu_da),
    .alu_db     (alu_db),
    .alu_out    (alu_out),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .err        (err),
`ifdef ALU_FLAGS_EN
    .flag_z     (flag_z),
    .flag_n     (flag_n),
`endif
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic expect_reg(input string nm, input logic [2:0] a, input logic [31:0] exp);
    host_addr = a;
    #1;
    checks++;
    if (host_rdata !== exp) $display("FAIL %s: r%0d got %h expected %h", nm, a, host_rdata, exp);
    else passed++;
  endtask

  // Runs one command from IDLE and checks every stage. The call starts and ends
  // 1 time unit after a rising edge.
  task automatic run_cmd(input string nm, input logic [15:0] op, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input logic [31:0] exp_da, input logic [31:0] exp_db,
                         input logic exp_legal, input logic [31:0] exp_data);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    tick(); // E0
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL %s ready_after_E0: got %b expected 0", nm, cmd_ready); else passed++;
    tick(); // E1
    checks++; if (alu_inst !== op)     $display("FAIL %s alu_inst: got %h expected %h", nm, alu_inst, op); else passed++;
    checks++; if (alu_da !== exp_da)   $display("FAIL %s alu_da: got %h expected %h", nm, alu_da, exp_da); else passed++;
    checks++; if (alu_db !== exp_db)   $display("FAIL %s alu_db: got %h expected %h", nm, alu_db, exp_db); else passed++;
    tick(); // E2
    checks++; if (wb_valid !== exp_legal) $display("FAIL %s wb_valid: got %b expected %b", nm, wb_valid, exp_legal); else passed++;
    checks++; if (err !== !exp_legal)     $display("FAIL %s err: got %b expected %b", nm, err, !exp_legal); else passed++;
    checks++; if (cmd_ready !== 1'b1)     $display("FAIL %s ready_after_E2: got %b expected 1", nm, cmd_ready); else passed++;
    if (exp_legal) begin
      checks++; if (wb_data !== exp_data) $display("FAIL %s wb_data: got %h expected %h", nm, wb_data, exp_data); else passed++;
      checks++; if (wb_rd !== rd)         $display("FAIL %s wb_rd: got %0d expected %0d", nm, wb_rd, rd); else passed++;
    end
    tick(); // pulses must have dropped
    checks++; if (wb_valid !== 1'b0) $display("FAIL %s wb_pulse_width: got %b expected 0", nm, wb_valid); else passed++;
    checks++; if (err !== 1'b0)      $display("FAIL %s err_pulse_width: got %b expected 0", nm, err); else passed++;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (wb_valid !== 1'b0 || err !== 1'b0) $display("FAIL reset_pulses: got wb_valid=%b err=%b expected 0/0", wb_valid, err); else passed++;
    checks++; if (alu_inst !== 16'h0 || alu_da !== 32'h0 || alu_db !== 32'h0)
      $display("FAIL reset_alu: got inst=%h da=%h db=%h expected zeros", alu_inst, alu_da, alu_db); else passed++;
    checks++; if (wb_rd !== 3'd0 || wb_data !== 32'h0) $display("FAIL reset_wb: got rd=%0d data=%h expected 0/0", wb_rd, wb_data); else passed++;
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cmd_ready); else passed++;
    for (int i = 0; i < 8; i++) expect_reg("reset_rf", 3'(i), 32'h0);
  endtask

  task automatic test_add();
    host_write(3'd1, 32'd5);
    host_write(3'd2, 32'd3);
    run_cmd("add", OP_ADD, 3'd3, 3'd1, 3'd2, 32'd5, 32'd3, 1'b1, 32'h0000_0008);
    expect_reg("add_rf", 3'd3, 32'h0000_0008);
`ifdef ALU_FLAGS_EN
    checks++; if (flag_z !== 1'b0 || flag_n !== 1'b0) $display("FAIL add_flags: got z=%b n=%b expected 0/0", flag_z, flag_n); else passed++;
`endif
  endtask

  task automatic test_sub();
    run_cmd("sub", OP_SUB, 3'd4, 3'd2, 3'd1, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE);
    expect_reg("sub_rf", 3'd4, 32'hFFFF_FFFE);
`ifdef ALU_FLAGS_EN
    checks++; if (flag_z !== 1'b0 || flag_n !== 1'b1) $display("FAIL sub_flags: got z=%b n=%b expected 0/1", flag_z, flag_n); else passed++;
`endif
  endtask

  task automatic test_illegal();
    run_cmd("illegal", 16'h0002, 3'd1, 3'd1, 3'd2, 32'd5, 32'd3, 1'b0, 32'h0);
    expect_reg("illegal_rf", 3'd1, 32'd5);
    checks++; if (wb_data !== 32'hFFFF_FFFE || wb_rd !== 3'd4)
      $display("FAIL illegal_wb_hold: got rd=%0d data=%h expected 4/fffffffe", wb_rd, wb_data); else passed++;
`ifdef ALU_FLAGS_EN
    checks++; if (flag_n !== 1'b1) $display("FAIL illegal_flags_hold: got n=%b expected 1", flag_n); else passed++;
`endif
  endtask

  // XOR r5=r1^r2=6, then AND r6=r5&r1=4 with cmd_valid held high throughout.
  // The second command's fields are presented while the first is in flight.
  task automatic test_back_to_back();
    int ready_low;
    ready_low = 0;
    cmd_valid = 1'b1; cmd_op = OP_XOR; cmd_rd = 3'd5; cmd_ra = 3'd1; cmd_rb = 3'd2;
    tick(); // E0 (A)
    cmd_op = OP_AND; cmd_rd = 3'd6; cmd_ra = 3'd5; cmd_rb = 3'd1;
    if (!cmd_ready) ready_low++;
    tick(); // E1
    if (!cmd_ready) ready_low++;
    tick(); // E2 (A written)
    checks++; if (ready_low !== 2) $display("FAIL b2b_ready_low: got %0d cycles expected 2", ready_low); else passed++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_at_E2: got %b expected 1", cmd_ready); else passed++;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd6 || wb_rd !== 3'd5)
      $display("FAIL b2b_first_wb: got v=%b rd=%0d data=%h expected 1/5/6", wb_valid, wb_rd, wb_data); else passed++;
    tick(); // E3 (B accepted)
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0 || wb_valid !== 1'b0)
      $display("FAIL b2b_accept_E3: got ready=%b wb_valid=%b expected 0/0", cmd_ready, wb_valid); else passed++;
    tick(); // E4
    checks++; if (alu_da !== 32'd6 || alu_db !== 32'd5 || alu_inst !== OP_AND)
      $display("FAIL b2b_operands: got inst=%h da=%h db=%h expected 0021/6/5", alu_inst, alu_da, alu_db); else passed++;
    checks++; if (wb_valid !== 1'b0) $display("FAIL b2b_gap: got wb_valid=%b expected 0", wb_valid); else passed++;
    tick(); // E5 (B written, 3 cycles after A)
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd4 || wb_rd !== 3'd6)
      $display("FAIL b2b_second_wb: got v=%b rd=%0d data=%h expected 1/6/4", wb_valid, wb_rd, wb_data); else passed++;
    tick();
  endtask

  // A host write at E1 must not affect the operands captured on that edge.
  task automatic test_read_snapshot();
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 3'd7; cmd_ra = 3'd1; cmd_rb = 3'd1;
    tick(); // E0
    cmd_valid = 1'b0;
    host_we = 1'b1; host_addr = 3'd1; host_wdata = 32'h100;
    tick(); // E1
    host_we = 1'b0;
    checks++; if (alu_da !== 32'd5 || alu_db !== 32'd5)
      $display("FAIL snapshot_operands: got da=%h db=%h expected 5/5", alu_da, alu_db); else passed++;
    tick(); // E2
    checks++; if (wb_data !== 32'd10) $display("FAIL snapshot_result: got %h expected a", wb_data); else passed++;
    expect_reg("snapshot_host_write", 3'd1, 32'h100);
    tick();
  endtask

  // OR r3 = 0x10 | 0x01 = 0x11, while the host writes 0xDEAD to r3 on the same E2 edge.
  task automatic test_collision();
    host_write(3'd1, 32'h10);
    host_write(3'd2, 32'h01);
    cmd_valid = 1'b1; cmd_op = OP_OR; cmd_rd = 3'd3; cmd_ra = 3'd1; cmd_rb = 3'd2;
    tick(); // E0
    cmd_valid = 1'b0;
    tick(); // E1
    host_we = 1'b1; host_addr = 3'd3; host_wdata = 32'hDEAD;
    tick(); // E2: collision
    host_we = 1'b0;
    checks++; if (wb_valid !== 1'b1) $display("FAIL collision_wb_valid: got %b expected 1", wb_valid); else passed++;
    expect_reg("collision_rf", 3'd3, 32'h11);
    tick();
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 3'd0; cmd_ra = 3'd1; cmd_rb = 3'd2;
    tick(); // E0
    cmd_valid = 1'b0;
    tick(); // E1 -> EXEC
    #2;
    rst = 1'b1;
    #1;
    checks++; if (alu_inst !== 16'h0 || alu_da !== 32'h0 || alu_db !== 32'h0)
      $display("FAIL midrst_alu: got inst=%h da=%h db=%h expected zeros", alu_inst, alu_da, alu_db); else passed++;
    checks++; if (wb_data !== 32'h0 || wb_rd !== 3'd0) $display("FAIL midrst_wb: got rd=%0d data=%h expected 0/0", wb_rd, wb_data); else passed++;
    tick();
    checks++; if (wb_valid !== 1'b0 || err !== 1'b0) $display("FAIL midrst_pulses: got wb_valid=%b err=%b expected 0/0", wb_valid, err); else passed++;
    for (int i = 0; i < 8; i++) expect_reg("midrst_rf", 3'(i), 32'h0);
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1 || wb_valid !== 1'b0)
      $display("FAIL midrst_release: got ready=%b wb_valid=%b expected 1/0", cmd_ready, wb_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_illegal();
    test_back_to_back();
    test_read_snapshot();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
